// File: rtl/mem_burst_reader.sv
// mem_burst_reader: burst read master for a 256x8 read-only memory port.
// Each accepted request (start address, length) becomes a sequence of
// single-beat memory accesses. The returned bytes are buffered in a small
// FIFO and leave as a valid/ready stream that flags the last beat of each burst.
module mem_burst_reader #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              mem_en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [ADDR_W-1:0]  r_cur_addr;
  logic [LEN_W-1:0]   r_remaining;
  logic               r_mem_en;

  // Each entry holds {data, last}.
  logic [DATA_W:0]    r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_req_fire;
  logic               w_push;
  logic               w_pop;
  logic               w_room;
  logic               w_last_beat;
  logic [DATA_W:0]    w_head;

  assign w_req_fire  = req_valid && (r_state == S_IDLE);
  assign w_push      = (r_state == S_ACCESS);
  assign w_pop       = out_ready && (r_count != '0);
  // A pop in this cycle frees a slot in time for the next access's push.
  assign w_room      = (r_count != FULL) || w_pop;
  assign w_last_beat = (r_remaining == LEN_W'(1));
  assign w_head      = r_fifo_mem[r_rd_ptr];

  // Next-state decode.
  always_comb begin
    // NOTE: assign a default before the case so every path drives the signal and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_req_fire && (req_len != '0)) w_next_state = S_SETUP;
      S_SETUP:  if (w_room) w_next_state = S_ACCESS;
      S_ACCESS: w_next_state = w_last_beat ? S_IDLE : S_SETUP;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Registered memory enable: high exactly for the cycle spent in ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_mem_en <= 1'b0;
    else        r_mem_en <= (w_next_state == S_ACCESS);
  end

  // Burst address and beat counter; the address register drives mem_addr directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr  <= '0;
      r_remaining <= '0;
    end else if (w_req_fire) begin
      r_cur_addr  <= req_addr;
      r_remaining <= req_len;
    end else if (w_push) begin
      r_cur_addr  <= r_cur_addr + ADDR_W'(1);
      r_remaining <= r_remaining - LEN_W'(1);
    end
  end

  // FIFO storage, written at the edge that ends each ACCESS cycle.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; the reset count marks every entry invalid and the outputs are gated.
    if (w_push) r_fifo_mem[r_wr_ptr] <= {mem_data, w_last_beat};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The SETUP room check guarantees a slot for every push.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && (r_count == FULL)));

  assign req_ready = (r_state == S_IDLE);
  assign mem_en    = r_mem_en;
  assign mem_rd    = r_mem_en;
  assign mem_addr  = r_cur_addr;
  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? w_head[DATA_W:1] : '0;
  assign out_last  = out_valid ? w_head[0] : 1'b0;
  assign busy      = (r_state != S_IDLE) || out_valid;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Bench for mem_burst_reader: memory model preloaded with i*i mod 256,
// directed bursts, and a scoreboard queue drained by an output monitor.
module tb_mem_burst_reader;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_addr;
  logic [8:0] req_len;
  logic       mem_en;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] addr_log[$];
  logic [7:0] mem_arr[256];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_pops   = 0;
  logic       prev_en;
  logic [7:0] prev_addr;

  mem_burst_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .mem_en    (mem_en),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data refreshes on each rising enable.
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'((i * i) % 256);
    mem_data = 8'h00;
  end
  always @(posedge mem_en) mem_data = mem_arr[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  // Returns 1 ns after the accepting edge.
  task automatic send_req(input logic [7:0] a, input logic [8:0] l);
    bit ok = 0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("req_accept");
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (!busy && sb.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now(name);
  endtask

  // Output monitor: every accepted beat is compared against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got data %0h last %0b with nothing expected", out_data, out_last);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_last", 32'(out_last), 32'(e.last));
      end
      n_pops++;
    end
  end

  // Memory-port protocol monitor: isolated enable pulses, stable address, strobes equal.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en   <= 1'b0;
      prev_addr <= mem_addr;
    end else begin
      if (mem_en) begin
        check("mem_en_back_to_back", 32'(prev_en), 32'd0);
        check("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
        check("mem_rd_eq_en", 32'(mem_rd), 32'(mem_en));
        addr_log.push_back(mem_addr);
      end
      prev_en   <= mem_en;
      prev_addr <= mem_addr;
    end
  end

  initial begin
    int   log_sz;
    int   pops0;
    bit   ok;
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    out_ready = 1'b1;

    // T1: asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_out_data",  32'(out_data),  32'd0);
    check("t1_out_last",  32'(out_last),  32'd0);
    check("t1_busy",      32'(busy),      32'd0);
    check("t1_req_ready", 32'(req_ready), 32'd1);
    check("t1_mem_en",    32'(mem_en),    32'd0);
    check("t1_mem_rd",    32'(mem_rd),    32'd0);
    check("t1_mem_addr",  32'(mem_addr),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // T2: basic burst with latency checks.
    addr_log.delete();
    expect_beat(8'd9, 1'b0);
    expect_beat(8'd16, 1'b0);
    expect_beat(8'd25, 1'b0);
    expect_beat(8'd36, 1'b1);
    send_req(8'd3, 9'd4);
    @(negedge clk);
    check("t2_setup_mem_en",    32'(mem_en),    32'd0);
    check("t2_setup_mem_addr",  32'(mem_addr),  32'd3);
    check("t2_setup_req_ready", 32'(req_ready), 32'd0);
    check("t2_setup_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t2_access_mem_en",    32'(mem_en),    32'd1);
    check("t2_access_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("t2_first_out_valid", 32'(out_valid), 32'd1);
    wait_drain("t2_drain");
    check("t2_pulse_count", 32'(addr_log.size()), 32'd4);
    check("t2_addr3", 32'(addr_log[3]), 32'd6);

    // T3: address wrap past 255.
    addr_log.delete();
    expect_beat(8'd4, 1'b0);
    expect_beat(8'd1, 1'b0);
    expect_beat(8'd0, 1'b1);
    send_req(8'd254, 9'd3);
    wait_drain("t3_drain");
    check("t3_pulse_count", 32'(addr_log.size()), 32'd3);
    check("t3_addr0", 32'(addr_log[0]), 32'd254);
    check("t3_addr1", 32'(addr_log[1]), 32'd255);
    check("t3_addr2", 32'(addr_log[2]), 32'd0);

    // T4: backpressure fills the FIFO and parks the FSM in SETUP.
    @(posedge clk); #1 out_ready = 1'b0;
    expect_beat(8'd0, 1'b0);
    expect_beat(8'd33, 1'b0);
    expect_beat(8'd68, 1'b0);
    expect_beat(8'd105, 1'b0);
    expect_beat(8'd144, 1'b0);
    expect_beat(8'd185, 1'b0);
    expect_beat(8'd228, 1'b0);
    expect_beat(8'd17, 1'b1);
    send_req(8'd16, 9'd8);
    repeat (16) @(negedge clk);
    check("t4_out_valid", 32'(out_valid), 32'd1);
    check("t4_head_data", 32'(out_data),  32'd0);
    check("t4_head_last", 32'(out_last),  32'd0);
    check("t4_park_addr", 32'(mem_addr),  32'd20);
    check("t4_busy",      32'(busy),      32'd1);
    check("t4_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_park_mem_en", 32'(mem_en),   32'd0);
      check("t4_hold_data",   32'(out_data), 32'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain("t4_drain");

    // T5: reset in the middle of a burst.
    expect_beat(8'd0, 1'b0);
    expect_beat(8'd1, 1'b0);
    pops0 = n_pops;
    send_req(8'd0, 9'd10);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (n_pops >= pops0 + 2) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("t5_two_beats");
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_en) begin
        ok = 1;
        break;
      end
    end
    if (!ok) fail_now("t5_third_access");
    #2 rst_n = 1'b0;
    #1;
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_mem_en",    32'(mem_en),    32'd0);
    check("t5_busy",      32'(busy),      32'd0);
    check("t5_req_ready", 32'(req_ready), 32'd1);
    check("t5_sb_empty",  32'(sb.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_beat(8'd25, 1'b1);
    send_req(8'd5, 9'd1);
    wait_drain("t5_single_drain");

    // T6: zero-length request is a no-op.
    log_sz = addr_log.size();
    send_req(8'h10, 9'd0);
    @(negedge clk);
    check("t6_req_ready", 32'(req_ready), 32'd1);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_busy",      32'(busy),      32'd0);
    repeat (4) @(negedge clk);
    check("t6_no_pulse",  32'(addr_log.size()), 32'(log_sz));
    check("t6_out_valid_late", 32'(out_valid), 32'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
